// File: rtl/rtc_field_editor.sv
// ---------------------------------------------------------------------------
// rtc_field_editor
//
// User-edit sequencer for the RTC datapath. A start pulse makes it write the
// timer control word. It then walks a table of BCD time/date fields. For each
// field it reads the current value and applies any pending increment or
// decrement, wrapping at that field's limits. The result goes to the RTC
// write arbiter through a req/ack handshake.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      begin a pass (only honoured while idle)
//   abort      synchronous cancel back to idle
//   timer_en   selects the control word, sampled when start is accepted
//   inc_flags  pending increment, one bit per field
//   dec_flags  pending decrement, one bit per field
//   fld_sel    index of the field being read
//   cur_val    BCD value of the selected field (valid one cycle after fld_sel)
//   wr_req     write request, held until wr_ack
//   wr_addr    write address
//   wr_data    write data
//   wr_ack     write accepted at an edge where wr_req && wr_ack
//   clr_flag   one-cycle pulse clearing the processed field's flags
//   clr_idx    field index qualified by clr_flag
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse at the end of a completed pass
// ---------------------------------------------------------------------------
module rtc_field_editor #(
    parameter int NUM_FIELDS = 9,
    parameter int DIGITS     = 2,
    parameter logic [NUM_FIELDS*4*DIGITS-1:0] FIELD_TOP =
        {8'h23, 8'h59, 8'h59, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59},
    parameter logic [NUM_FIELDS*4*DIGITS-1:0] FIELD_MIN =
        {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00},
    parameter logic [NUM_FIELDS*8-1:0] FIELD_ADDR =
        {8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21},
    parameter logic [7:0] CTRL_ADDR     = 8'h00,
    parameter logic [7:0] TIMER_RUN_VAL = 8'h08,
    parameter bit         WRITE_ALL     = 1'b1,
    localparam int DW = 4*DIGITS,
    localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  timer_en,
    input  logic [NUM_FIELDS-1:0] inc_flags,
    input  logic [NUM_FIELDS-1:0] dec_flags,
    output logic [FW-1:0]         fld_sel,
    input  logic [DW-1:0]         cur_val,
    output logic                  wr_req,
    output logic [7:0]            wr_addr,
    output logic [DW-1:0]         wr_data,
    input  logic                  wr_ack,
    output logic                  clr_flag,
    output logic [FW-1:0]         clr_idx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        READ,
        CALC,
        WRITE,
        NEXT,
        DONE
    } state_t;

    // The control value is zero-extended first, then cut to DW bits, so that
    // one expression works whether DW is wider or narrower than 8.
    localparam logic [DW+7:0] CTRL_EXT    = {{DW{1'b0}}, TIMER_RUN_VAL};
    localparam logic [DW-1:0] CTRL_RUN_DW = CTRL_EXT[DW-1:0];
    localparam logic [FW-1:0] LAST_IDX    = FW'(NUM_FIELDS - 1);

    state_t          state_q,   state_d;
    logic [FW-1:0]   idx_q,     idx_d;
    logic [DW-1:0]   newVal_q,  newVal_d;
    logic            flagHit_q, flagHit_d;
    logic            timerEn_q, timerEn_d;

    logic [DW-1:0]   fieldTop;
    logic [DW-1:0]   fieldMin;
    logic [7:0]      fieldAddr;
    logic            incHit;
    logic            decHit;
    logic            outOfRange;
    logic [DW-1:0]   calcVal;

    // BCD +1 or -1 across all digits. Only the digit that hits 9 (on the way
    // up) or 0 (on the way down) passes a carry or borrow to the next one.
    function automatic logic [DW-1:0] bcdStep(input logic [DW-1:0] val,
                                              input logic          up);
        logic [DW-1:0] res;
        logic          ripple;
        res    = val;
        ripple = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (ripple) begin
                if (up) begin
                    if (val[4*d +: 4] == 4'd9) begin
                        res[4*d +: 4] = 4'd0;
                    end else begin
                        res[4*d +: 4] = val[4*d +: 4] + 4'd1;
                        ripple        = 1'b0;
                    end
                end else begin
                    if (val[4*d +: 4] == 4'd0) begin
                        res[4*d +: 4] = 4'd9;
                    end else begin
                        res[4*d +: 4] = val[4*d +: 4] - 4'd1;
                        ripple        = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    // Per-field limits and the edited value for the field selected now.
    // A value outside [min,top] is treated as corrupt. It is snapped to the
    // limit the edit moves toward, the same as a normal wrap.
    always_comb begin
        fieldTop   = FIELD_TOP[idx_q*DW +: DW];
        fieldMin   = FIELD_MIN[idx_q*DW +: DW];
        fieldAddr  = FIELD_ADDR[idx_q*8 +: 8];
        incHit     = inc_flags[idx_q];
        decHit     = dec_flags[idx_q];
        outOfRange = (cur_val < fieldMin) || (cur_val > fieldTop);
        calcVal    = cur_val;
        if (incHit && !decHit) begin
            if ((cur_val == fieldTop) || outOfRange) begin
                calcVal = fieldMin;
            end else begin
                calcVal = bcdStep(cur_val, 1'b1);
            end
        end else if (decHit && !incHit) begin
            if ((cur_val == fieldMin) || outOfRange) begin
                calcVal = fieldTop;
            end else begin
                calcVal = bcdStep(cur_val, 1'b0);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            newVal_q  <= '0;
            flagHit_q <= 1'b0;
            timerEn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            newVal_q  <= newVal_d;
            flagHit_q <= flagHit_d;
            timerEn_q <= timerEn_d;
        end
    end

    // Next-state logic. abort overrides every transition outside IDLE, so a
    // write that is acked in the same cycle as abort is still dropped.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        newVal_d  = newVal_q;
        flagHit_d = flagHit_q;
        timerEn_d = timerEn_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    timerEn_d = timer_en;
                    state_d   = CTRL;
                end
            end
            CTRL: begin
                if (wr_ack) begin
                    idx_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = CALC;
            end
            CALC: begin
                newVal_d  = calcVal;
                flagHit_d = incHit | decHit;
                if (!WRITE_ALL && !(incHit | decHit)) begin
                    state_d = NEXT;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (wr_ack) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = READ;
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            idx_d     = '0;
            flagHit_d = 1'b0;
        end
    end

    // Outputs are decoded from registered state only. Because of that, an
    // asynchronous reset clears them at once, and all write fields stay
    // stable while a request waits for ack.
    always_comb begin
        busy     = (state_q != IDLE);
        wr_req   = 1'b0;
        wr_addr  = 8'h00;
        wr_data  = '0;
        clr_flag = 1'b0;
        clr_idx  = '0;
        done     = (state_q == DONE);
        fld_sel  = idx_q;
        case (state_q)
            CTRL: begin
                wr_req  = 1'b1;
                wr_addr = CTRL_ADDR;
                wr_data = timerEn_q ? CTRL_RUN_DW : '0;
            end
            WRITE: begin
                wr_req  = 1'b1;
                wr_addr = fieldAddr;
                wr_data = newVal_q;
            end
            NEXT: begin
                clr_flag = flagHit_q;
                clr_idx  = flagHit_q ? idx_q : '0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_field_editor.sv
// ---------------------------------------------------------------------------
// tb_rtc_field_editor
//
// Directed bench for rtc_field_editor using its default parameters. A second
// instance with WRITE_ALL=0 covers the skip-write pass. The field contents
// come from a small table that the bench indexes with fld_sel. Every
// accepted write and clear pulse is logged so each scenario can compare
// them with hand-computed values.
// ---------------------------------------------------------------------------
module tb_rtc_field_editor;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       startSkip;
    logic       abort;
    logic       timer_en;
    logic [8:0] inc_flags;
    logic [8:0] dec_flags;
    logic [3:0] fld_sel;
    logic [7:0] cur_val;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       clr_flag;
    logic [3:0] clr_idx;
    logic       busy;
    logic       done;

    logic [3:0] fldSelSkip;
    logic [7:0] curValSkip;
    logic       wrReqSkip;
    logic [7:0] wrAddrSkip;
    logic [7:0] wrDataSkip;
    logic       clrFlagSkip;
    logic [3:0] clrIdxSkip;
    logic       busySkip;
    logic       doneSkip;

    logic [7:0] curVals [9];

    int assertions = 0;
    int failures   = 0;

    logic [7:0] wrAddrLog [512];
    logic [7:0] wrDataLog [512];
    logic [3:0] clrLog    [512];
    int wrCount      = 0;
    int clrCount     = 0;
    int doneCount    = 0;
    int skipWrCount  = 0;
    int wrBase       = 0;
    int clrBase      = 0;
    int doneBase     = 0;
    int skipBase     = 0;

    assign cur_val    = curVals[fld_sel];
    assign curValSkip = curVals[fldSelSkip];

    rtc_field_editor dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .timer_en  (timer_en),
        .inc_flags (inc_flags),
        .dec_flags (dec_flags),
        .fld_sel   (fld_sel),
        .cur_val   (cur_val),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .clr_flag  (clr_flag),
        .clr_idx   (clr_idx),
        .busy      (busy),
        .done      (done)
    );

    rtc_field_editor #(.WRITE_ALL(1'b0)) dutSkip (
        .clk       (clk),
        .reset     (reset),
        .start     (startSkip),
        .abort     (abort),
        .timer_en  (timer_en),
        .inc_flags (inc_flags),
        .dec_flags (dec_flags),
        .fld_sel   (fldSelSkip),
        .cur_val   (curValSkip),
        .wr_req    (wrReqSkip),
        .wr_addr   (wrAddrSkip),
        .wr_data   (wrDataSkip),
        .wr_ack    (wr_ack),
        .clr_flag  (clrFlagSkip),
        .clr_idx   (clrIdxSkip),
        .busy      (busySkip),
        .done      (doneSkip)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Log handshakes on the falling edge. Inputs only change just after a
    // rising edge, so what is seen here is what the next rising edge accepts.
    always @(negedge clk) begin
        if (wr_req && wr_ack) begin
            wrAddrLog[wrCount] <= wr_addr;
            wrDataLog[wrCount] <= wr_data;
            wrCount            <= wrCount + 1;
        end
        if (clr_flag) begin
            clrLog[clrCount] <= clr_idx;
            clrCount         <= clrCount + 1;
        end
        if (done) begin
            doneCount <= doneCount + 1;
        end
        if (wrReqSkip && wr_ack) begin
            skipWrCount <= skipWrCount + 1;
        end
    end

    task automatic markLogs();
        wrBase   = wrCount;
        clrBase  = clrCount;
        doneBase = doneCount;
        skipBase = skipWrCount;
    endtask

    // One pass: the start edge counts as cycle 1, and the count stops at the
    // edge after which done is visible. wr_ack is pulled low for holdN
    // cycles while the request at holdAddr is pending. The task also reports
    // whether the pending request changed during that stall.
    task automatic runPass(input bit useSkip, input logic te,
                           input logic [7:0] holdAddr, input int holdN,
                           output int cycles, output int held,
                           output bit stallChanged);
        logic [7:0] firstAddr;
        logic [7:0] firstData;
        firstAddr    = 8'h00;
        firstData    = 8'h00;
        held         = 0;
        stallChanged = 1'b0;
        @(posedge clk); #1;
        if (useSkip) startSkip = 1'b1; else start = 1'b1;
        timer_en = te;
        wr_ack   = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        startSkip = 1'b0;
        cycles    = 1;
        while (cycles < 200) begin
            if (!useSkip && wr_req && wr_addr == holdAddr && held < holdN) begin
                if (held == 0) begin
                    firstAddr = wr_addr;
                    firstData = wr_data;
                end else if (!wr_req || wr_addr != firstAddr || wr_data != firstData) begin
                    stallChanged = 1'b1;
                end
                wr_ack = 1'b0;
                held++;
            end else begin
                wr_ack = 1'b1;
            end
            @(negedge clk);
            if (useSkip ? doneSkip : done) break;
            @(posedge clk); #1;
            cycles++;
        end
        wr_ack = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        assertions++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_req !== 1'b0) begin
            $display("[TB] FAIL reset_ctrl: busy/done/wr_req=%b%b%b expected 000", busy, done, wr_req);
            failures++;
        end
        assertions++;
        if (wr_addr !== 8'h00 || wr_data !== 8'h00 || fld_sel !== 4'd0) begin
            $display("[TB] FAIL reset_data: addr=%h data=%h sel=%0d expected 00 00 0", wr_addr, wr_data, fld_sel);
            failures++;
        end
        assertions++;
        if (clr_flag !== 1'b0 || clr_idx !== 4'd0) begin
            $display("[TB] FAIL reset_clr: clr_flag=%b clr_idx=%0d expected 0 0", clr_flag, clr_idx);
            failures++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_no_flags();
        int cycles, held;
        bit chg;
        inc_flags = '0;
        dec_flags = '0;
        markLogs();
        runPass(1'b0, 1'b1, 8'hFF, 0, cycles, held, chg);
        assertions++;
        if (cycles !== 38) begin
            $display("[TB] FAIL noflag_cycles: got %0d expected 38", cycles);
            failures++;
        end
        assertions++;
        if (wrCount - wrBase !== 10) begin
            $display("[TB] FAIL noflag_writes: got %0d expected 10", wrCount - wrBase);
            failures++;
        end
        assertions++;
        if (wrAddrLog[wrBase] !== 8'h00 || wrDataLog[wrBase] !== 8'h08) begin
            $display("[TB] FAIL noflag_ctrl: got %h/%h expected 00/08", wrAddrLog[wrBase], wrDataLog[wrBase]);
            failures++;
        end
        for (int i = 0; i < 9; i++) begin
            logic [7:0] expAddr;
            expAddr = (i < 6) ? 8'(8'h21 + i) : 8'(8'h41 + i - 6);
            assertions++;
            if (wrAddrLog[wrBase+1+i] !== expAddr || wrDataLog[wrBase+1+i] !== curVals[i]) begin
                $display("[TB] FAIL noflag_field%0d: got %h/%h expected %h/%h", i,
                         wrAddrLog[wrBase+1+i], wrDataLog[wrBase+1+i], expAddr, curVals[i]);
                failures++;
            end
        end
        assertions++;
        if (clrCount - clrBase !== 0 || doneCount - doneBase !== 1) begin
            $display("[TB] FAIL noflag_pulses: clr=%0d done=%0d expected 0 1", clrCount - clrBase, doneCount - doneBase);
            failures++;
        end
    endtask

    task automatic test_wrap();
        int cycles, held;
        bit chg;
        curVals[0] = 8'h59;
        curVals[3] = 8'h01;
        curVals[4] = 8'h09;
        inc_flags  = 9'b0_0001_0001;
        dec_flags  = 9'b0_0000_1000;
        markLogs();
        runPass(1'b0, 1'b0, 8'hFF, 0, cycles, held, chg);
        assertions++;
        if (cycles !== 38) begin
            $display("[TB] FAIL wrap_cycles: got %0d expected 38", cycles);
            failures++;
        end
        assertions++;
        if (wrDataLog[wrBase] !== 8'h00) begin
            $display("[TB] FAIL wrap_ctrl_off: got %h expected 00", wrDataLog[wrBase]);
            failures++;
        end
        assertions++;
        if (wrAddrLog[wrBase+1] !== 8'h21 || wrDataLog[wrBase+1] !== 8'h00) begin
            $display("[TB] FAIL wrap_sec_inc: got %h/%h expected 21/00", wrAddrLog[wrBase+1], wrDataLog[wrBase+1]);
            failures++;
        end
        assertions++;
        if (wrAddrLog[wrBase+4] !== 8'h24 || wrDataLog[wrBase+4] !== 8'h31) begin
            $display("[TB] FAIL wrap_day_dec: got %h/%h expected 24/31", wrAddrLog[wrBase+4], wrDataLog[wrBase+4]);
            failures++;
        end
        assertions++;
        if (wrAddrLog[wrBase+5] !== 8'h25 || wrDataLog[wrBase+5] !== 8'h10) begin
            $display("[TB] FAIL wrap_carry: got %h/%h expected 25/10", wrAddrLog[wrBase+5], wrDataLog[wrBase+5]);
            failures++;
        end
        assertions++;
        if (clrCount - clrBase !== 3 || clrLog[clrBase] !== 4'd0 ||
            clrLog[clrBase+1] !== 4'd3 || clrLog[clrBase+2] !== 4'd4) begin
            $display("[TB] FAIL wrap_clr: count=%0d idx=%0d,%0d,%0d expected 3 0,3,4", clrCount - clrBase,
                     clrLog[clrBase], clrLog[clrBase+1], clrLog[clrBase+2]);
            failures++;
        end
        inc_flags  = '0;
        dec_flags  = '0;
        curVals[0] = 8'h12;
        curVals[3] = 8'h15;
    endtask

    task automatic test_month_edges();
        logic [7:0] vecCur [5] = '{8'h12, 8'h10, 8'h00, 8'h99, 8'h01};
        logic       vecInc [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] vecExp [5] = '{8'h01, 8'h09, 8'h01, 8'h01, 8'h12};
        int cycles, held;
        bit chg;
        for (int v = 0; v < 5; v++) begin
            curVals[4] = vecCur[v];
            inc_flags  = vecInc[v] ? 9'h010 : 9'h000;
            dec_flags  = vecInc[v] ? 9'h000 : 9'h010;
            markLogs();
            runPass(1'b0, 1'b1, 8'hFF, 0, cycles, held, chg);
            assertions++;
            if (wrAddrLog[wrBase+5] !== 8'h25 || wrDataLog[wrBase+5] !== vecExp[v]) begin
                $display("[TB] FAIL month_vec%0d: got %h/%h expected 25/%h", v,
                         wrAddrLog[wrBase+5], wrDataLog[wrBase+5], vecExp[v]);
                failures++;
            end
        end
        inc_flags  = '0;
        dec_flags  = '0;
        curVals[4] = 8'h07;
    endtask

    task automatic test_both_flags();
        int cycles, held;
        bit chg;
        curVals[2] = 8'h15;
        inc_flags  = 9'h004;
        dec_flags  = 9'h004;
        markLogs();
        runPass(1'b0, 1'b1, 8'hFF, 0, cycles, held, chg);
        assertions++;
        if (wrAddrLog[wrBase+3] !== 8'h23 || wrDataLog[wrBase+3] !== 8'h15) begin
            $display("[TB] FAIL both_value: got %h/%h expected 23/15", wrAddrLog[wrBase+3], wrDataLog[wrBase+3]);
            failures++;
        end
        assertions++;
        if (clrCount - clrBase !== 1 || clrLog[clrBase] !== 4'd2) begin
            $display("[TB] FAIL both_clr: count=%0d idx=%0d expected 1 2", clrCount - clrBase, clrLog[clrBase]);
            failures++;
        end
        inc_flags  = '0;
        dec_flags  = '0;
        curVals[2] = 8'h05;
    endtask

    task automatic test_skip_writes();
        int cycles, held;
        bit chg;
        markLogs();
        runPass(1'b1, 1'b1, 8'hFF, 0, cycles, held, chg);
        assertions++;
        if (cycles !== 29) begin
            $display("[TB] FAIL skip_cycles: got %0d expected 29", cycles);
            failures++;
        end
        assertions++;
        if (skipWrCount - skipBase !== 1) begin
            $display("[TB] FAIL skip_writes: got %0d expected 1", skipWrCount - skipBase);
            failures++;
        end
    endtask

    task automatic test_ack_stall();
        int cycles, held;
        bit chg;
        markLogs();
        runPass(1'b0, 1'b1, 8'h22, 5, cycles, held, chg);
        assertions++;
        if (cycles !== 43 || held !== 5) begin
            $display("[TB] FAIL stall_cycles: got %0d (held %0d) expected 43 (held 5)", cycles, held);
            failures++;
        end
        assertions++;
        if (chg !== 1'b0) begin
            $display("[TB] FAIL stall_stable: request changed while waiting, got 1 expected 0");
            failures++;
        end
        assertions++;
        if (wrAddrLog[wrBase+2] !== 8'h22 || wrDataLog[wrBase+2] !== curVals[1]) begin
            $display("[TB] FAIL stall_write: got %h/%h expected 22/%h", wrAddrLog[wrBase+2], wrDataLog[wrBase+2], curVals[1]);
            failures++;
        end
    endtask

    task automatic test_abort();
        bit found;
        found     = 1'b0;
        inc_flags = 9'h010;
        markLogs();
        @(posedge clk); #1;
        start    = 1'b1;
        timer_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (wr_req && wr_addr == 8'h25) begin
                wr_ack = 1'b0;
                abort  = 1'b1;
                found  = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        assertions++;
        if (!found) begin
            $display("[TB] FAIL abort_reach: field 4 write seen=0 expected 1");
            failures++;
        end
        @(posedge clk); #1;
        abort  = 1'b0;
        wr_ack = 1'b1;
        assertions++;
        if (wr_req !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL abort_idle: wr_req=%b busy=%b expected 0 0", wr_req, busy);
            failures++;
        end
        repeat (5) @(posedge clk);
        #1;
        assertions++;
        if (doneCount - doneBase !== 0 || clrCount - clrBase !== 0 || wrCount - wrBase !== 5) begin
            $display("[TB] FAIL abort_effects: done=%0d clr=%0d writes=%0d expected 0 0 5",
                     doneCount - doneBase, clrCount - clrBase, wrCount - wrBase);
            failures++;
        end
        inc_flags = '0;
    endtask

    task automatic test_async_reset();
        int cycles, held;
        bit chg;
        @(posedge clk); #1;
        start    = 1'b1;
        timer_en = 1'b1;
        wr_ack   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        assertions++;
        if (wr_req !== 1'b1 || wr_data !== 8'h08) begin
            $display("[TB] FAIL areset_pre: wr_req=%b data=%h expected 1 08", wr_req, wr_data);
            failures++;
        end
        #2 reset = 1'b1;
        #1;
        assertions++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || wr_addr !== 8'h00 || wr_data !== 8'h00 ||
            fld_sel !== 4'd0 || done !== 1'b0 || clr_flag !== 1'b0) begin
            $display("[TB] FAIL areset_outputs: req=%b busy=%b addr=%h data=%h sel=%0d expected all 0",
                     wr_req, busy, wr_addr, wr_data, fld_sel);
            failures++;
        end
        #1 reset = 1'b0;
        wr_ack = 1'b1;
        markLogs();
        runPass(1'b0, 1'b1, 8'hFF, 0, cycles, held, chg);
        assertions++;
        if (cycles !== 38 || wrCount - wrBase !== 10 || doneCount - doneBase !== 1) begin
            $display("[TB] FAIL areset_fresh: cycles=%0d writes=%0d done=%0d expected 38 10 1",
                     cycles, wrCount - wrBase, doneCount - doneBase);
            failures++;
        end
    endtask

    // Scenario sequence
    initial begin
        start     = 1'b0;
        startSkip = 1'b0;
        abort     = 1'b0;
        timer_en  = 1'b0;
        inc_flags = '0;
        dec_flags = '0;
        wr_ack    = 1'b1;
        curVals   = '{8'h12, 8'h34, 8'h05, 8'h15, 8'h07, 8'h42, 8'h33, 8'h44, 8'h20};
        test_reset();
        test_no_flags();
        test_wrap();
        test_month_edges();
        test_both_flags();
        test_skip_writes();
        test_ack_stall();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/rtc_field_editor.md
# rtc_field_editor

Parametrised user-edit sequencer for the RTC datapath. After a start pulse it writes the timer control word, then walks a configurable table of BCD time/date fields. For each field it reads the current value, applies a pending increment or decrement with per-field wrap limits, and writes the result to the RTC bus through a req/ack handshake. It sits between the push-button flag registers and the RTC write arbiter, and supersedes the fixed 9-field, 2-digit user machine.

## Interface
- NUM_FIELDS, 9, number of fields processed per pass (1..16)
- DIGITS, 2, BCD digits per field; DW = 4*DIGITS
- FIELD_TOP, {8'h23,8'h59,8'h59,8'h99,8'h12,8'h31,8'h23,8'h59,8'h59}, packed NUM_FIELDS*DW; field 0 at LSB; inclusive maximum per field
- FIELD_MIN, {8'h00,8'h00,8'h00,8'h00,8'h01,8'h01,8'h00,8'h00,8'h00}, packed; inclusive minimum (day/month = 01)
- FIELD_ADDR, {8'h43,8'h42,8'h41,8'h26,8'h25,8'h24,8'h23,8'h22,8'h21}, packed NUM_FIELDS*8; RTC write address per field
- CTRL_ADDR, 8'h00, timer control register address
- TIMER_RUN_VAL, 8'h08, control data written when timer_en=1 (0 otherwise)
- WRITE_ALL, 1, 1: write every field; 0: skip write for fields with no pending flag
- FW = max(1, clog2(NUM_FIELDS)) (local)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  begin a pass; honoured only in IDLE
- abort  input  1  synchronous cancel to IDLE
- timer_en  input  1  sampled on start acceptance
- inc_flags  input  NUM_FIELDS  pending increment per field
- dec_flags  input  NUM_FIELDS  pending decrement per field
- fld_sel  output  FW  field index being read
- cur_val  input  DW  BCD value of fld_sel, valid one cycle after fld_sel changes
- wr_req  output  1  write request, held until accepted
- wr_addr  output  8  write address
- wr_data  output  DW  write data (control value zero-extended/truncated to DW)
- wr_ack  input  1  accepts the write at the edge where wr_req && wr_ack
- clr_flag  output  1  one-cycle pulse clearing the processed field's flags
- clr_idx  output  FW  index for clr_flag
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse at the end of a completed pass

## Operation
- Reset values: all outputs 0; state IDLE; field counter 0; latched timer_en 0.
- IDLE: on start, latch timer_en and go to CTRL.
- CTRL: drive wr_req=1, wr_addr=CTRL_ADDR, wr_data=TIMER_RUN_VAL or 0; hold until ack, then set fld_sel=0 and go to READ.
- READ: one cycle, waiting for cur_val.
- CALC: sample cur_val, inc_flags[i] and dec_flags[i], then compute the new value:
  - inc only: if val==top or val outside [min,top], new=min; else BCD +1, carry rippling across DIGITS (digit 9→0).
  - dec only: if val==min or val outside [min,top], new=top; else BCD −1, borrow rippling (digit 0→9).
  - both or neither: new=val.
  - Comparisons are unsigned on the raw DW-bit value.
- CALC then goes to WRITE, or straight to NEXT if WRITE_ALL=0 and no flag is set.
- WRITE: wr_req=1, wr_addr=FIELD_ADDR[i], wr_data=new; hold all three stable until ack.
- NEXT:
  - Pulse clr_flag with clr_idx=i if either flag was sampled set.
  - If i==NUM_FIELDS−1, go to DONE.
  - Else i+1 → fld_sel and go to READ.
- DONE: pulse done, reset i to 0, return to IDLE.
- abort in any non-IDLE state:
  - Next edge: wr_req=0, busy=0, go to IDLE.
  - No done, no clr_flag.
  - Any write not yet acknowledged is dropped.
- start while busy: ignored.
- reset mid-pass: outputs return to reset values immediately (asynchronously).

## Timing
- start → wr_req high at edge+1.
- wr_req falls on the edge after the acking edge.
- With wr_ack tied high:
  - CTRL = 1 cycle.
  - Each written field = 4 cycles (READ, CALC, WRITE, NEXT).
  - Each skipped field = 3 cycles.
  - DONE = 1 cycle.
  - Default full pass = 1 + 9·4 + 1 = 38 cycles, start to done.
- Each extra cycle wr_ack is low adds one cycle.
- flags are sampled only in CALC; flag changes at other times affect the next pass.
- fld_sel is stable from READ through NEXT.

## Test plan
- Default params, ack tied high, timer_en=1, no flags → writes (00,08), then 21..43 with unchanged values; done at cycle 38.
- Field 0 cur=59, inc_flags[0]=1 → wr_data 00 at 0x21, clr_flag with clr_idx=0. Field 3 cur=01, dec → 31 at 0x24.
- Field 4 cur=09, inc → 10; cur=12, inc → 01; cur=10, dec → 09; cur=00 (invalid), inc → 01.
- inc and dec both set on field 2, cur=15 → 15 written, clr_flag pulsed. WRITE_ALL=0 with no flags → only the CTRL write occurs; pass takes 29 cycles.
- wr_ack held low 5 cycles during field 1 → wr_req/addr/data stable throughout; pass length 43 cycles.
- abort during field 4 WRITE → wr_req low next cycle, busy 0, no done. Async reset mid-CTRL → all outputs 0 without a clock edge; a fresh start afterwards completes normally.
